// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side control of the asynchronous FIFO.
// Keeps the binary/Gray write pointers, brings the read-domain Gray pointer
// into wclk, and produces the RAM write address/enable, full flag, fill level
// and a sticky overflow flag.
// Optional feature macro: WAFULL_EN adds a registered almost-full output
// (wafull) that asserts when the fill level reaches AFULL_LEVEL.
module fifo_wptr_full #(
    parameter int ADDSIZE     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LEVEL = 240
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic               winc,
    input  logic [ADDSIZE:0]   rptr,
    input  logic               wovf_clr,
    output logic [ADDSIZE-1:0] waddr,
    output logic               wclken,
    output logic               wfull,
    output logic [ADDSIZE:0]   wptr,
    output logic [ADDSIZE:0]   wlevel,
    output logic               wovf
`ifdef WAFULL_EN
    ,
    output logic               wafull
`endif
);

    logic [ADDSIZE:0]                   wbin;
    logic [ADDSIZE:0]                   wbin_next;
    logic [ADDSIZE:0]                   wgray_next;
    logic [ADDSIZE:0]                   level_next;
    logic [ADDSIZE:0]                   rq_bin;
    logic                               full_next;
    logic [SYNC_STAGES-1:0][ADDSIZE:0]  rq_chain;
    logic [ADDSIZE:0]                   rq_sync;

    // Gray-to-binary conversion: each binary bit is the XOR of all Gray bits above and including it.
    function automatic logic [ADDSIZE:0] gray2bin(input logic [ADDSIZE:0] g);
        logic [ADDSIZE:0] b;
        b[ADDSIZE] = g[ADDSIZE];
        for (int i = ADDSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign rq_sync = rq_chain[SYNC_STAGES-1];
    assign wclken  = winc & ~wfull;
    assign waddr   = wbin[ADDSIZE-1:0];

    // Next pointer, level and full are all derived from the synchronised read pointer, never from rptr directly.
    always_comb begin
        wbin_next  = wbin + {{ADDSIZE{1'b0}}, wclken};
        wgray_next = (wbin_next >> 1) ^ wbin_next;
        rq_bin     = gray2bin(rq_sync);
        level_next = wbin_next - rq_bin;
        full_next  = (wgray_next == {~rq_sync[ADDSIZE:ADDSIZE-1], rq_sync[ADDSIZE-2:0]});
    end

    // Plain flop chain carrying the read Gray pointer into wclk; nothing may sit between the stages.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rq_chain <= '0;
        end else begin
            rq_chain <= {rq_chain[SYNC_STAGES-2:0], rptr};
        end
    end

    // Pointer, full and level registers; full lands on the same edge as the write that fills the FIFO.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            wlevel <= '0;
        end else begin
            wbin   <= wbin_next;
            wptr   <= wgray_next;
            wfull  <= full_next;
            wlevel <= level_next;
        end
    end

    // Sticky overflow: a rejected write sets it, and a set in the same cycle beats a clear.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wovf <= 1'b0;
        end else if (winc & wfull) begin
            wovf <= 1'b1;
        end else if (wovf_clr) begin
            wovf <= 1'b0;
        end
    end

`ifdef WAFULL_EN
    localparam logic [ADDSIZE:0] AFULL_THR = (ADDSIZE+1)'(AFULL_LEVEL);

    // Almost-full tracks the level being loaded, so it is always set whenever full is.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wafull <= 1'b0;
        end else begin
            wafull <= (level_next >= AFULL_THR);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: randomized self-checking bench for fifo_wptr_full.
// The reference model counts writes and reads as plain integers and lets the
// read count reach the write side two wclk edges after it is sampled.
module tb_fifo_wptr_full;

    localparam int ADDSIZE     = 4;
    localparam int DEPTH       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int AFULL_LEVEL = 12;

    logic         wclk = 1'b0;
    logic         wrst_n;
    logic         winc;
    logic [4:0]   rptr;
    logic         wovf_clr;
    logic [3:0]   waddr;
    logic         wclken;
    logic         wfull;
    logic [4:0]   wptr;
    logic [4:0]   wlevel;
    logic         wovf;
`ifdef WAFULL_EN
    logic         wafull;
`endif

    fifo_wptr_full #(
        .ADDSIZE     (ADDSIZE),
        .SYNC_STAGES (SYNC_STAGES),
        .AFULL_LEVEL (AFULL_LEVEL)
    ) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .winc     (winc),
        .rptr     (rptr),
        .wovf_clr (wovf_clr),
        .waddr    (waddr),
        .wclken   (wclken),
        .wfull    (wfull),
        .wptr     (wptr),
        .wlevel   (wlevel),
        .wovf     (wovf)
`ifdef WAFULL_EN
        ,
        .wafull   (wafull)
`endif
    );

    // Free-running write clock, period 10.
    always #5 wclk = ~wclk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: total writes accepted, total reads done, and the
    // read counts sampled on the last two edges.
    int wcount;
    int rcount;
    int rs0;
    int rs1;
    int expLevel;
    bit expFull;
    bit expOvf;

    function automatic logic [4:0] gray(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".waddr"},  32'(waddr),  32'(wcount % DEPTH));
        checkOutput({tag, ".wptr"},   32'(wptr),   32'(gray(wcount)));
        checkOutput({tag, ".wlevel"}, 32'(wlevel), 32'(expLevel));
        checkOutput({tag, ".wfull"},  32'(wfull),  32'(expFull));
        checkOutput({tag, ".wovf"},   32'(wovf),   32'(expOvf));
`ifdef WAFULL_EN
        checkOutput({tag, ".wafull"}, 32'(wafull), 32'(expLevel >= AFULL_LEVEL));
`endif
    endtask

    task automatic modelReset();
        wcount   = 0;
        rcount   = 0;
        rs0      = 0;
        rs1      = 0;
        expLevel = 0;
        expFull  = 1'b0;
        expOvf   = 1'b0;
    endtask

    // One wclk cycle, entered and left at a falling edge. rd reads are
    // applied to rptr at a random point in the low phase.
    task automatic applyStimulus(input bit w, input bit clr, input int rd);
        int   rdn;
        bit   accepted;
        logic [4:0] prevWptr;
        winc     = w;
        wovf_clr = clr;
        #1;
        checkOutput("wclken", 32'(wclken), 32'(w & ~expFull));
        checkOutput("waddr_pre", 32'(waddr), 32'(wcount % DEPTH));
        #($urandom_range(0, 2));
        rdn = rd;
        if (rdn > wcount - rcount) rdn = wcount - rcount;
        rcount = rcount + rdn;
        rptr   = gray(rcount);
        prevWptr = wptr;
        @(posedge wclk);
        accepted = w && !expFull;
        if (w && expFull) expOvf = 1'b1;
        else if (clr)     expOvf = 1'b0;
        if (accepted) wcount++;
        expLevel = wcount - rs1;
        expFull  = (expLevel == DEPTH);
        rs1 = rs0;
        rs0 = rcount;
        #1;
        checkAll("edge");
        checkOutput("wptr_step", 32'($countones(wptr ^ prevWptr)), 32'(accepted));
        @(negedge wclk);
    endtask

    // Asynchronous reset asserted in the low phase, checked before any edge.
    task automatic doReset();
        #2;
        wrst_n = 1'b0;
        winc   = 1'b0;
        rptr   = '0;
        #1;
        modelReset();
        checkAll("reset");
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    int accCount;
    int startW;
    bit w;
    int rd;

    initial begin
        wrst_n   = 1'b0;
        winc     = 1'b0;
        wovf_clr = 1'b0;
        rptr     = '0;
        modelReset();
        #1;
        checkAll("por");
        @(negedge wclk);
        wrst_n = 1'b1;

        // Fill to 16 with the reader idle.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 0);
        checkOutput("full16", 32'(wfull), 32'd1);
        checkOutput("level16", 32'(wlevel), 32'd16);
        checkOutput("wptr16", 32'(wptr), 32'b11000);

        // Writes while full are rejected and flagged.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 0);
        checkOutput("ovf_addr", 32'(waddr), 32'd0);
        checkOutput("ovf_wptr", 32'(wptr), 32'b11000);
        checkOutput("ovf_set", 32'(wovf), 32'd1);
        applyStimulus(1'b0, 1'b1, 0);
        checkOutput("ovf_clr", 32'(wovf), 32'd0);

        // One read frees a slot after the synchroniser delay.
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("rptr_gray1", 32'(rptr), 32'b00001);
        applyStimulus(1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("unfull", 32'(wfull), 32'd0);
        checkOutput("level15", 32'(wlevel), 32'd15);
        checkOutput("addr_after_read", 32'(waddr), 32'd0);
        applyStimulus(1'b1, 1'b0, 0);

        // Drain to a mid level, then 40 writes with the reader tracking behind.
        for (int i = 0; i < 20 && (wcount - rcount) > 6; i++) applyStimulus(1'b0, 1'b0, 2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 0);
        accCount = 0;
        for (int cyc = 0; cyc < 300 && accCount < 40; cyc++) begin
            w  = ($urandom_range(0, 3) != 0);
            rd = ((wcount - rcount) >= 6) ? int'($urandom_range(1, 2)) : 0;
            startW = wcount;
            applyStimulus(w, 1'b0, rd);
            if (wcount > startW) accCount++;
            checkOutput("no_full", 32'(wfull), 32'd0);
        end
        checkOutput("wrap_writes", 32'(accCount), 32'd40);

        // Reset in the middle of a burst at level 9.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 0);
        for (int i = 0; i < 40 && expLevel > 9; i++) applyStimulus(1'b0, 1'b0, 1);
        for (int i = 0; i < 40 && expLevel < 9; i++) applyStimulus(1'b1, 1'b0, 0);
        checkOutput("level9", 32'(wlevel), 32'd9);
        winc = 1'b1;
        doReset();
        checkOutput("post_reset_addr", 32'(waddr), 32'd0);
        applyStimulus(1'b1, 1'b0, 0);

        // Random traffic in alternating write-heavy and read-heavy phases.
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ((cyc / 50) % 2 == 0) begin
                w  = ($urandom_range(0, 7) != 0);
                rd = ($urandom_range(0, 3) == 0) ? 1 : 0;
            end else begin
                w  = ($urandom_range(0, 3) == 0);
                rd = int'($urandom_range(0, 2));
            end
            applyStimulus(w, ($urandom_range(0, 7) == 0), rd);
        end

`ifdef WAFULL_EN
        // Almost-full threshold crossing in both directions.
        doReset();
        for (int i = 0; i < AFULL_LEVEL - 1; i++) applyStimulus(1'b1, 1'b0, 0);
        checkOutput("afull_11", 32'(wafull), 32'd0);
        applyStimulus(1'b1, 1'b0, 0);
        checkOutput("afull_12", 32'(wafull), 32'd1);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("afull_hold", 32'(wafull), 32'd1);
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("afull_drop", 32'(wafull), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-side control stage of the asynchronous FIFO. Sits directly upstream of the dual-port RAM and drives its write address, write enable and full flag.
- Keeps a binary and a Gray-coded write pointer, and synchronises the read-domain Gray pointer into the write clock.
- Generates a registered full flag, fill level and sticky overflow indication.
- Exports the Gray write pointer for the read-side empty logic.

Parameters:
- ADDSIZE, 8, RAM address width; FIFO depth DEPTH = 1<<ADDSIZE; pointers are ADDSIZE+1 bits.
- SYNC_STAGES, 2, flop stages in the read-pointer synchroniser; legal values 2..4.
- AFULL_LEVEL, 240, almost-full threshold; used only when the optional feature is compiled in; legal range 1..DEPTH-1.

Ports:
- wclk  in  1  write-domain clock; all flops on its rising edge.
- wrst_n  in  1  asynchronous active-low reset; assertion is immediate, release is synchronous to wclk externally.
- winc  in  1  write request for the current cycle.
- rptr  in  ADDSIZE+1  Gray read pointer from the read domain (asynchronous to wclk).
- wovf_clr  in  1  clears the sticky overflow flag.
- waddr  out  ADDSIZE  RAM write address (binary pointer LSBs).
- wclken  out  1  RAM write enable.
- wfull  out  1  FIFO full, registered.
- wptr  out  ADDSIZE+1  registered Gray write pointer to the read domain.
- wlevel  out  ADDSIZE+1  registered fill level, 0..DEPTH.
- wovf  out  1  sticky overflow: a write was attempted while full.
- wafull  out  1  almost full; present only with WAFULL_EN.

Behaviour:
- Reset (wrst_n=0, asynchronous): wbin, wptr, waddr, all synchroniser flops, wfull, wlevel, wovf (and wafull) go to 0. Reset asserted mid-operation discards all state. No write is accepted while in reset.
- Accept rule: wclken = winc & ~wfull, combinational from the registered wfull. A write is accepted only on an edge where wclken=1.
- Pointer update: wbin_next = wbin + wclken, modulo 2^(ADDSIZE+1).
  - wgray_next = (wbin_next>>1) ^ wbin_next.
  - wbin and wptr register their next values on every edge.
  - waddr = wbin[ADDSIZE-1:0], so the address for an accepted write is the value before the increment.
- Synchroniser: rptr passes through a SYNC_STAGES-deep flop chain, giving rq_sync. No logic sits between the stages. Only wptr (registered Gray) crosses to the read domain.
- Full:
  - wfull registers (wgray_next == {~rq_sync[ADDSIZE:ADDSIZE-1], rq_sync[ADDSIZE-2:0]}).
  - wfull asserts on the same edge that accepts the DEPTH-th outstanding write, so there is zero-cycle latency to block the next write.
  - Deassertion after a read is pessimistic: SYNC_STAGES+1 wclk edges after rptr changes.
- Level: wlevel registers wbin_next - gray2bin(rq_sync), modulo 2^(ADDSIZE+1). The value is always 0..DEPTH and never underflows. Reads are reflected with the synchroniser delay.
- Overflow:
  - wovf sets on an edge with winc=1 & wfull=1. Pointers do not move.
  - wovf_clr=1 clears it. If set and clear coincide, set wins.
- Wrap-around: the binary pointer wraps from 2^(ADDSIZE+1)-1 to 0. Gray code guarantees a single-bit change per increment, including at wrap.
- Simultaneous write and read-pointer change on one edge: both take effect. Full and level use the synchronised value present before that edge.
- No combinational path from rptr to any output.

Optional Feature:
- Macro WAFULL_EN.
- Defined: adds output wafull, registered, = (level_next >= AFULL_LEVEL), where level_next is the value being loaded into wlevel. Reset value 0. wafull is always 1 whenever wfull is 1.
- Undefined: the wafull port and its logic are absent. All other behaviour is identical.

Test Plan (bench uses ADDSIZE=4, DEPTH=16, SYNC_STAGES=2, AFULL_LEVEL=12; rptr driven in a wclk-asynchronous manner):
- Reset, then hold winc=1 for 16 cycles with rptr=0 -> waddr steps 0..15, wclken=1 on each of those edges; wfull=1 right after the 16th edge; wlevel=16; wptr=5'b11000.
- Continue winc=1 while full for 3 cycles -> wclken=0; waddr stays 0; wptr unchanged; wovf=1; pulse wovf_clr -> wovf=0.
- From full, step rptr to Gray(1)=5'b00001 -> wfull=0 and wlevel=15 within 3 wclk edges; next winc accepted at waddr=0.
- Run 40 writes with the reader keeping level 4..8 -> pointer wraps past 31 to 0; wptr changes exactly 1 bit per accepted write; wfull never asserts.
- Assert wrst_n=0 mid-burst at level 9 -> all outputs 0 immediately without a clock edge; after release, the first write goes to waddr=0.
- With WAFULL_EN: fill to 11 -> wafull=0; 12th write -> wafull=1; read back to 11 -> wafull=0 after the synchroniser delay. Without WAFULL_EN: compiles with no wafull port.
